// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM generator with dead-time insertion, duty clamping and fault latch.
// Optional mid on-time ADC strobe is built only when PWM_ADC_TRIG_EN is defined.
module pwm_deadtime_gen #(
   parameter int DEADTIME = 4,
   parameter int DUTY_MIN = 8,
   parameter int DUTY_MAX = 247
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] duty_in,
   input  logic       duty_valid,
   input  logic       fault,
   input  logic       fault_clr,
   output logic       gate_hi,
   output logic       gate_lo,
   output logic       period_start,
   output logic       adc_trig,
   output logic [7:0] duty_act,
   output logic       fault_latched
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_DT_LH = 3'd1;
   localparam logic [2:0] ST_HI_ON = 3'd2;
   localparam logic [2:0] ST_DT_HL = 3'd3;
   localparam logic [2:0] ST_LO_ON = 3'd4;
   localparam logic [2:0] ST_FAULT = 3'd5;

   localparam int DT_W = (DEADTIME < 2) ? 1 : $clog2(DEADTIME);
   localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME - 1);
   localparam logic [7:0] DUTY_MIN_B = 8'(DUTY_MIN);
   localparam logic [7:0] DUTY_MAX_B = 8'(DUTY_MAX);

   generate
      if (DEADTIME < 1 || DUTY_MIN <= DEADTIME || (255 - DUTY_MAX) < DEADTIME ||
          DUTY_MIN > DUTY_MAX || DUTY_MAX > 255) begin : g_param_check
         $error("pwm_deadtime_gen: illegal DEADTIME/DUTY_MIN/DUTY_MAX combination");
      end
   endgenerate

   logic [2:0]      state_reg, state_next;
   logic [7:0]      cnt_reg, cnt_next;
   logic [DT_W-1:0] dt_reg, dt_next;
   logic [7:0]      pend_reg, pend_next;
   logic [7:0]      duty_reg, duty_next;
   logic            gate_hi_reg, gate_lo_reg, period_start_reg, fault_latched_reg;
   logic            hi_phase, run_next;

   function automatic logic [7:0] clamp_duty(input logic [7:0] d);
      if (d < DUTY_MIN_B)      return DUTY_MIN_B;
      else if (d > DUTY_MAX_B) return DUTY_MAX_B;
      else                     return d;
   endfunction

   assign hi_phase = (cnt_reg < duty_reg);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      dt_next    = dt_reg;
      duty_next  = duty_reg;
      pend_next  = duty_valid ? duty_in : pend_reg;
      if (fault) begin
         state_next = ST_FAULT;
         cnt_next   = 8'd0;
         dt_next    = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               cnt_next = 8'd0;
               if (enable) begin
                  state_next = ST_DT_LH;
                  dt_next    = '0;
                  duty_next  = clamp_duty(pend_reg);
               end
            end
            ST_FAULT: begin
               cnt_next = 8'd0;
               if (fault_clr) state_next = ST_IDLE;
            end
            default: begin
               if (!enable) begin
                  state_next = ST_IDLE;
                  cnt_next   = 8'd0;
                  dt_next    = '0;
               end else begin
                  cnt_next = cnt_reg + 8'd1;
                  // Duty only changes across the period boundary.
                  if (cnt_reg == 8'd255) duty_next = clamp_duty(pend_reg);
                  case (state_reg)
                     ST_DT_LH: begin
                        if (dt_reg == DT_LAST) begin
                           state_next = ST_HI_ON;
                           dt_next    = '0;
                        end else begin
                           dt_next = dt_reg + 1'b1;
                        end
                     end
                     ST_HI_ON: begin
                        if (!hi_phase) begin
                           state_next = ST_DT_HL;
                           dt_next    = '0;
                        end
                     end
                     ST_DT_HL: begin
                        if (dt_reg == DT_LAST) begin
                           state_next = ST_LO_ON;
                           dt_next    = '0;
                        end else begin
                           dt_next = dt_reg + 1'b1;
                        end
                     end
                     ST_LO_ON: begin
                        if (hi_phase) begin
                           state_next = ST_DT_LH;
                           dt_next    = '0;
                        end
                     end
                     default: begin
                        state_next = ST_IDLE;
                        cnt_next   = 8'd0;
                        dt_next    = '0;
                     end
                  endcase
               end
            end
         endcase
      end
   end

   assign run_next = (state_next == ST_DT_LH) || (state_next == ST_HI_ON) ||
                     (state_next == ST_DT_HL) || (state_next == ST_LO_ON);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= ST_IDLE;
         cnt_reg           <= 8'd0;
         dt_reg            <= '0;
         pend_reg          <= 8'd128;
         duty_reg          <= 8'd128;
         gate_hi_reg       <= 1'b0;
         gate_lo_reg       <= 1'b0;
         period_start_reg  <= 1'b0;
         fault_latched_reg <= 1'b0;
      end else begin
         state_reg         <= state_next;
         cnt_reg           <= cnt_next;
         dt_reg            <= dt_next;
         pend_reg          <= pend_next;
         duty_reg          <= duty_next;
         // Gates decode the next state, so they can never overlap.
         gate_hi_reg       <= (state_next == ST_HI_ON);
         gate_lo_reg       <= (state_next == ST_LO_ON);
         period_start_reg  <= run_next && (cnt_next == 8'd0);
         fault_latched_reg <= (state_next == ST_FAULT);
      end
   end

`ifdef PWM_ADC_TRIG_EN
   logic adc_trig_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         adc_trig_reg <= 1'b0;
      end else begin
         adc_trig_reg <= ((state_next == ST_HI_ON) || (state_next == ST_DT_LH)) &&
                         (cnt_next == (duty_next >> 1));
      end
   end

   assign adc_trig = adc_trig_reg;
`else
   assign adc_trig = 1'b0;
`endif

   assign gate_hi       = gate_hi_reg;
   assign gate_lo       = gate_lo_reg;
   assign period_start  = period_start_reg;
   assign duty_act      = duty_reg;
   assign fault_latched = fault_latched_reg;

endmodule

// File: doc/pwm_deadtime_gen.md
PWM_DEADTIME_GEN -- requirements
Module: pwm_deadtime_gen

Interface
REQ-001 SHALL have parameter DEADTIME, default 4: clocks with both gates low at every gate transition.
REQ-002 SHALL have parameter DUTY_MIN, default 8: lower clamp on the applied duty.
REQ-003 SHALL have parameter DUTY_MAX, default 247: upper clamp on the applied duty.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: run the modulator.
REQ-007 SHALL have port duty_in, input, 8 bits: requested duty from the MPPT controller.
REQ-008 SHALL have port duty_valid, input, 1 bit: qualifies duty_in.
REQ-009 SHALL have port fault, input, 1 bit: overcurrent/overvoltage shutdown request.
REQ-010 SHALL have port fault_clr, input, 1 bit: releases the latched fault.
REQ-011 SHALL have port gate_hi, output, 1 bit: high-side switch drive.
REQ-012 SHALL have port gate_lo, output, 1 bit: low-side switch drive.
REQ-013 SHALL have port period_start, output, 1 bit: 1-cycle pulse at the start of each period.
REQ-014 SHALL have port adc_trig, output, 1 bit: 1-cycle ADC sample strobe.
REQ-015 SHALL have port duty_act, output, 8 bits: the clamped duty in force this period.
REQ-016 SHALL have port fault_latched, output, 1 bit: shutdown is active.

Function
REQ-017 SHALL run an 8-bit period counter cnt, 0..255 with wrap to 0, while in a running state; the period is 256 clocks.
REQ-018 SHALL capture duty_in into a pending register on any cycle with duty_valid=1; the last write wins.
REQ-019 SHALL load duty_act = clamp(pending, DUTY_MIN, DUTY_MAX) only on the cycle cnt==255 and on leaving IDLE, so there are no mid-period duty changes.
REQ-020 SHALL define hi_phase = (cnt < duty_act).
REQ-021 SHALL implement FSM states IDLE, DT_LH, HI_ON, DT_HL, LO_ON, FAULT; both gates are low in IDLE, DT_LH, DT_HL and FAULT.
REQ-022 SHALL move IDLE->DT_LH when enable=1, with cnt starting at 0.
REQ-023 SHALL make DT_LH last exactly DEADTIME clocks and then enter HI_ON, where gate_hi=1.
REQ-024 SHALL move HI_ON->DT_HL on the first cycle hi_phase=0; DT_HL lasts DEADTIME clocks, then LO_ON (gate_lo=1).
REQ-025 SHALL move LO_ON->DT_LH on the first cycle hi_phase=1.
REQ-026 SHALL give registered gate outputs, 1-clock latency from cnt; per steady period, gate_hi is high for duty_act-DEADTIME clocks and gate_lo for 256-duty_act-DEADTIME clocks.
REQ-027 SHALL never assert gate_hi and gate_lo in the same cycle, under any input sequence.
REQ-028 SHALL, when enable=0 in any running state, drive both gates low and enter IDLE on the next edge, with cnt cleared to 0.
REQ-029 SHALL, when fault=1 in any state, enter FAULT on the next edge with both gates low and fault_latched=1.
REQ-030 SHALL leave FAULT to IDLE only on a cycle with fault_clr=1 and fault=0; if fault and fault_clr are both 1, fault wins.
REQ-031 SHALL pulse period_start for one cycle when cnt==0 in a running state.
REQ-032 SHALL reject illegal parameters at elaboration: DUTY_MIN must be > DEADTIME and 255-DUTY_MAX must be >= DEADTIME.

Reset
REQ-033 SHALL, with rst=1 at a clock edge, set: FSM=IDLE, cnt=0, pending=128, duty_act=128, gate_hi=0, gate_lo=0, period_start=0, adc_trig=0, fault_latched=0.
REQ-034 SHALL give rst priority over fault, enable and duty_valid; reset mid-period forces both gates low on that edge.

Configuration
REQ-035 SHALL use macro PWM_ADC_TRIG_EN: when defined, adc_trig pulses for one cycle when cnt==(duty_act>>1) in HI_ON or DT_LH, i.e. mid on-time.
REQ-036 SHALL, when PWM_ADC_TRIG_EN is undefined, tie adc_trig to 0 and synthesise no compare logic for it.

Verification
REQ-037 SHALL cover: enable=1, duty 128 -> gate_hi high 124 clocks and gate_lo high 124 clocks per period, with 4-clock dead gaps at each transition.
REQ-038 SHALL cover: duty_in=0, then 255 -> duty_act=8 (gate_hi 4 clocks), then 247 (gate_lo 5 clocks).
REQ-039 SHALL cover: duty_valid with 64 at cnt=100 of a duty-128 period -> current period unchanged; next period duty_act=64.
REQ-040 SHALL cover: fault=1 during HI_ON -> both gates low next edge, fault_latched=1; fault_clr with fault=1 ignored; fault_clr with fault=0 -> IDLE, then restart through DT_LH.
REQ-041 SHALL cover: with PWM_ADC_TRIG_EN and duty 128 -> adc_trig a single pulse at cnt=64; without the macro -> adc_trig always 0.
REQ-042 SHALL cover: rst=1 asserted for one cycle mid LO_ON -> all outputs at reset values next edge and gate_lo=0; random stimulus never shows gate_hi&gate_lo.
